// File: rtl/soml_frame_scheduler_if.sv
// Host-load and decoder-stream signals of the SOML frame scheduler.
// slave = scheduler side, master = host/decoder side.
interface soml_frame_scheduler_if #(
  parameter int N = 32
);
  logic         h_wr_valid;
  logic         h_wr_ready;
  logic [N-1:0] h_wr_r;
  logic [N-1:0] h_wr_i;
  logic         y_wr_valid;
  logic         y_wr_ready;
  logic [N-1:0] y_wr_r;
  logic [N-1:0] y_wr_i;
  logic         dec_start;
  logic         dec_H_valid;
  logic [N-1:0] dec_H_r;
  logic [N-1:0] dec_H_i;
  logic         dec_Y_valid;
  logic [N-1:0] dec_Y_r;
  logic [N-1:0] dec_Y_i;
  logic         dec_output_valid;
  logic         busy;
  logic [15:0]  frames_done;
  logic         timeout_err;

  modport slave (
    input  h_wr_valid, h_wr_r, h_wr_i, y_wr_valid, y_wr_r, y_wr_i, dec_output_valid,
    output h_wr_ready, y_wr_ready, dec_start, dec_H_valid, dec_H_r, dec_H_i,
           dec_Y_valid, dec_Y_r, dec_Y_i, busy, frames_done, timeout_err
  );

  modport master (
    output h_wr_valid, h_wr_r, h_wr_i, y_wr_valid, y_wr_r, y_wr_i, dec_output_valid,
    input  h_wr_ready, y_wr_ready, dec_start, dec_H_valid, dec_H_r, dec_H_i,
           dec_Y_valid, dec_Y_r, dec_Y_i, busy, frames_done, timeout_err
  );
endinterface

// File: rtl/soml_frame_scheduler.sv
// Holds one H matrix and a queue of Y matrices; replays H with each queued Y
// as one decoder frame (start, parallel H/Y stream, wait for result, gap).
module soml_frame_scheduler #(
  parameter int N       = 32,
  parameter int H_SIZE  = 16,
  parameter int Y_SIZE  = 8,
  parameter int Y_DEPTH = 4,
  parameter int GAP     = 10,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  soml_frame_scheduler_if.slave  bus
);
  localparam int FD = Y_DEPTH * Y_SIZE;
  localparam int PW = $clog2(FD);
  localparam int HW = $clog2(H_SIZE);
  localparam int WW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_WAIT, S_GAP} state_t;

  state_t          r_state, w_next;
  logic [N-1:0]    r_h_r [H_SIZE];
  logic [N-1:0]    r_h_i [H_SIZE];
  logic [N-1:0]    r_y_r [FD];
  logic [N-1:0]    r_y_i [FD];
  logic [HW-1:0]   r_h_cnt, r_hidx, w_hsel;
  logic            r_h_loaded;
  logic [PW:0]     r_wptr, r_rptr, w_count;
  logic [WW-1:0]   r_wcnt;
  logic [GW-1:0]   r_gcnt;
  logic [15:0]     r_frames;
  logic            r_tout;
  logic            r_h_vld, r_y_vld;
  logic [N-1:0]    r_hr, r_hi, r_yr, r_yi;
  logic            w_full, w_y_avail, w_h_acc, w_h_last, w_y_push;
  logic            w_h_emit, w_y_emit, w_tmo;

  assign w_count   = r_wptr - r_rptr;
  assign w_full    = (w_count == (PW+1)'(FD));
  assign w_y_avail = (w_count >= (PW+1)'(Y_SIZE));
  assign w_h_acc   = bus.h_wr_valid && (r_state == S_IDLE);
  assign w_h_last  = (r_h_cnt == HW'(H_SIZE - 1));
  assign w_y_push  = bus.y_wr_valid && !w_full;
  assign w_tmo     = (r_state == S_WAIT) && !bus.dec_output_valid &&
                     (r_wcnt == WW'(TIMEOUT - 1));

  // Stream registers are loaded one cycle ahead: START preloads element 0,
  // STREAM cycle k preloads element k+1. Y pops ride on the same preload.
  always_comb begin
    w_next   = r_state;
    w_h_emit = 1'b0;
    w_y_emit = 1'b0;
    w_hsel   = '0;
    case (r_state)
      S_IDLE:   if (r_h_loaded && w_y_avail && !bus.h_wr_valid) w_next = S_START;
      S_START: begin
        w_next   = S_STREAM;
        w_h_emit = 1'b1;
        w_y_emit = 1'b1;
      end
      S_STREAM: begin
        if (r_hidx == HW'(H_SIZE - 1)) begin
          w_next = S_WAIT;
        end else begin
          w_h_emit = 1'b1;
          w_hsel   = r_hidx + 1'b1;
          w_y_emit = (r_hidx < HW'(Y_SIZE - 1));
        end
      end
      S_WAIT:   if (bus.dec_output_valid || w_tmo) w_next = S_GAP;
      S_GAP:    if (r_gcnt == GW'(GAP - 1)) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_h_cnt    <= '0;
      r_h_loaded <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_hidx     <= '0;
      r_wcnt     <= '0;
      r_gcnt     <= '0;
      r_frames   <= '0;
      r_tout     <= 1'b0;
      r_h_vld    <= 1'b0;
      r_y_vld    <= 1'b0;
      r_hr       <= '0;
      r_hi       <= '0;
      r_yr       <= '0;
      r_yi       <= '0;
    end else begin
      r_state <= w_next;
      // A write after a complete load restarts the matrix at index 0.
      if (w_h_acc) begin
        r_h_cnt    <= w_h_last ? '0 : r_h_cnt + 1'b1;
        r_h_loaded <= w_h_last;
      end
      if (w_y_push) r_wptr <= r_wptr + 1'b1;
      if (w_y_emit) r_rptr <= r_rptr + 1'b1;
      r_hidx <= (r_state == S_STREAM) ? r_hidx + 1'b1 : '0;
      r_wcnt <= (r_state == S_WAIT)   ? r_wcnt + 1'b1 : '0;
      r_gcnt <= (r_state == S_GAP)    ? r_gcnt + 1'b1 : '0;
      if (r_state == S_WAIT && bus.dec_output_valid) r_frames <= r_frames + 1'b1;
      if (w_tmo) r_tout <= 1'b1;
      r_h_vld <= w_h_emit;
      r_y_vld <= w_y_emit;
      if (w_h_emit) begin
        r_hr <= r_h_r[w_hsel];
        r_hi <= r_h_i[w_hsel];
      end
      if (w_y_emit) begin
        r_yr <= r_y_r[r_rptr[PW-1:0]];
        r_yi <= r_y_i[r_rptr[PW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_h_acc) begin
      r_h_r[r_h_cnt] <= bus.h_wr_r;
      r_h_i[r_h_cnt] <= bus.h_wr_i;
    end
    if (w_y_push) begin
      r_y_r[r_wptr[PW-1:0]] <= bus.y_wr_r;
      r_y_i[r_wptr[PW-1:0]] <= bus.y_wr_i;
    end
  end

  assign bus.h_wr_ready  = (r_state == S_IDLE);
  assign bus.y_wr_ready  = !w_full;
  assign bus.dec_start   = (r_state == S_START);
  assign bus.dec_H_valid = r_h_vld;
  assign bus.dec_H_r     = r_hr;
  assign bus.dec_H_i     = r_hi;
  assign bus.dec_Y_valid = r_y_vld;
  assign bus.dec_Y_r     = r_yr;
  assign bus.dec_Y_i     = r_yi;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.frames_done = r_frames;
  assign bus.timeout_err = r_tout;
endmodule
